timer_sched: RTL and testbench

//  Multi-channel timeout scheduler sharing one prescaled tick among NUM_CH requesters.

---
 rtl/timer_sched_pkg.sv | 23 ++
 rtl/timer_sched_ch.sv | 76 +++++++
 rtl/timer_sched.sv | 64 ++++++
 tb/tb_timer_sched.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_sched_pkg.sv
// Shared types for the multi-channel timeout scheduler: channel state, per-channel
// timing configuration and the zero-to-one length saturation helper.
package timer_sched_pkg;

  // Widest supported timeout length; channel counters are this wide internally.
  localparam int CNT_W_MAX = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } state_e;

  typedef struct packed {
    logic [CNT_W_MAX-1:0] remaining;
    logic [CNT_W_MAX-1:0] reload;
    logic                 periodic;
  } ch_cfg_t;

  function automatic logic [CNT_W_MAX-1:0] sat1(input logic [CNT_W_MAX-1:0] cycles);
    return (cycles == '0) ? CNT_W_MAX'(1) : cycles;
  endfunction

endpackage

// File: rtl/timer_sched_ch.sv
// One scheduler channel: IDLE/ARMED FSM, tick-down counter with optional reload,
// registered expiry pulse and sticky pending bit. CNT_W must not exceed CNT_W_MAX.
module timer_sched_ch
  import timer_sched_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             tick_i,
  input  logic             req_valid_i,
  input  logic [CNT_W-1:0] req_cycles_i,
  input  logic             req_periodic_i,
  input  logic             cancel_i,
  input  logic             pend_clr_i,
  output logic             req_ready_o,
  output state_e           state_o,
  output logic             expire_o,
  output logic             pend_o
);

  state_e               state_q;
  ch_cfg_t              cfg_q;
  logic                 expire_q;
  logic                 pend_q;
  logic                 fire;
  logic [CNT_W_MAX-1:0] cycles_ext;

  assign cycles_ext  = CNT_W_MAX'(req_cycles_i);
  assign req_ready_o = (state_q == ST_IDLE) & en_i & ~cancel_i;
  // A cancel in the final-tick cycle suppresses both the pulse and the pending set.
  assign fire = (state_q == ST_ARMED) & tick_i & ~cancel_i &
                (cfg_q.remaining == CNT_W_MAX'(1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cfg_q    <= '0;
      expire_q <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      expire_q <= fire;
      // Setting wins over a clear both in the expiry cycle and in the pulse cycle.
      pend_q   <= (pend_q & ~pend_clr_i) | fire | expire_q;
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i && req_ready_o) begin
            cfg_q.remaining <= sat1(cycles_ext);
            cfg_q.reload    <= sat1(cycles_ext);
            cfg_q.periodic  <= req_periodic_i;
            state_q         <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (cancel_i) begin
            state_q <= ST_IDLE;
          end else if (tick_i) begin
            if (cfg_q.remaining == CNT_W_MAX'(1)) begin
              if (cfg_q.periodic) cfg_q.remaining <= cfg_q.reload;
              else                state_q         <= ST_IDLE;
            end else begin
              cfg_q.remaining <= cfg_q.remaining - CNT_W_MAX'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign state_o  = state_q;
  assign expire_o = expire_q;
  assign pend_o   = pend_q;

endmodule

// File: rtl/timer_sched.sv
// Multi-channel timeout scheduler: a shared prescaler tick drives NUM_CH independent
// one-shot/periodic channels whose sticky pending bits are ORed into one interrupt.
module timer_sched
  import timer_sched_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int DIV_W  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic [DIV_W-1:0]        div_i,
  input  logic [NUM_CH-1:0]       req_valid_i,
  output logic [NUM_CH-1:0]       req_ready_o,
  input  logic [NUM_CH*CNT_W-1:0] req_cycles_i,
  input  logic [NUM_CH-1:0]       req_periodic_i,
  input  logic [NUM_CH-1:0]       cancel_i,
  output logic [NUM_CH-1:0]       busy_o,
  output logic [NUM_CH-1:0]       expire_o,
  input  logic [NUM_CH-1:0]       pend_clr_i,
  output logic [NUM_CH-1:0]       pend_o,
  output logic                    irq_o
);

  logic [DIV_W-1:0] psc_q, psc_d;
  logic             tick;
  state_e           ch_state [NUM_CH];

  // A divisor lowered below the current count wraps the prescaler without a tick.
  always_comb begin
    psc_d = psc_q;
    if (en_i) psc_d = (psc_q >= div_i) ? '0 : psc_q + DIV_W'(1);
  end

  assign tick = en_i & (psc_q == div_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) psc_q <= '0;
    else       psc_q <= psc_d;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    timer_sched_ch #(.CNT_W(CNT_W)) u_ch (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .en_i           (en_i),
      .tick_i         (tick),
      .req_valid_i    (req_valid_i[g]),
      .req_cycles_i   (req_cycles_i[g*CNT_W +: CNT_W]),
      .req_periodic_i (req_periodic_i[g]),
      .cancel_i       (cancel_i[g]),
      .pend_clr_i     (pend_clr_i[g]),
      .req_ready_o    (req_ready_o[g]),
      .state_o        (ch_state[g]),
      .expire_o       (expire_o[g]),
      .pend_o         (pend_o[g])
    );
    assign busy_o[g] = (ch_state[g] == ST_ARMED);
  end

  assign irq_o = |pend_o;

endmodule

// File: tb/tb_timer_sched.sv
// Bench for timer_sched: deadline-based reference model checked every cycle,
// a latency vector table, directed corner sequences and a randomized phase.
module tb_timer_sched;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 32;
  localparam int DIV_W  = 16;
  localparam int OW     = 3*NUM_CH + 1;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    en;
  logic [DIV_W-1:0]        div;
  logic [NUM_CH-1:0]       valid, ready, periodic, cancel, busy, expire, pclr, pend;
  logic [NUM_CH*CNT_W-1:0] cycles;
  logic                    irq;

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 1'b0;

  always #5 clk = ~clk;

  timer_sched #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .en_i           (en),
    .div_i          (div),
    .req_valid_i    (valid),
    .req_ready_o    (ready),
    .req_cycles_i   (cycles),
    .req_periodic_i (periodic),
    .cancel_i       (cancel),
    .busy_o         (busy),
    .expire_o       (expire),
    .pend_clr_i     (pclr),
    .pend_o         (pend),
    .irq_o          (irq)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference model: channels hold an absolute deadline on a global tick count.
  bit                m_armed [NUM_CH];
  bit                m_per   [NUM_CH];
  longint            m_dl    [NUM_CH];
  longint            m_rl    [NUM_CH];
  longint            m_tk;
  int                m_psc;
  logic [NUM_CH-1:0] m_exp, m_pend;
  logic [OW-1:0]     exp_q[$];

  always @(posedge clk) begin
    logic [NUM_CH-1:0] fire;
    logic [NUM_CH-1:0] mb;
    bit                tick;
    longint            n;
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        m_armed[k] = 1'b0; m_per[k] = 1'b0; m_dl[k] = 0; m_rl[k] = 0;
      end
      m_tk = 0; m_psc = 0; m_exp = '0; m_pend = '0;
    end else begin
      tick = en && (m_psc == int'(div));
      if (tick) m_tk++;
      fire = '0;
      for (int k = 0; k < NUM_CH; k++) begin
        if (m_armed[k]) begin
          if (cancel[k]) m_armed[k] = 1'b0;
          else if (tick && m_tk == m_dl[k]) begin
            fire[k] = 1'b1;
            if (m_per[k]) m_dl[k] += m_rl[k];
            else          m_armed[k] = 1'b0;
          end
        end else if (valid[k] && en && !cancel[k]) begin
          n = longint'(cycles[k*CNT_W +: CNT_W]);
          if (n == 0) n = 1;
          m_armed[k] = 1'b1; m_rl[k] = n; m_dl[k] = m_tk + n; m_per[k] = periodic[k];
        end
      end
      m_pend = (m_pend & ~pclr) | fire | m_exp;
      m_exp  = fire;
      if (en) m_psc = (m_psc >= int'(div)) ? 0 : m_psc + 1;
    end
    for (int k = 0; k < NUM_CH; k++) mb[k] = m_armed[k];
    exp_q.push_back({mb, m_exp, m_pend, |m_pend});
  end

  always @(negedge clk) begin
    logic [OW-1:0]     e;
    logic [NUM_CH-1:0] er;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (chk_on && !rst) begin
        check("model_out", {busy, expire, pend, irq}, e);
        for (int k = 0; k < NUM_CH; k++) er[k] = !m_armed[k] && en && !cancel[k];
        check("model_ready", ready, er);
      end
    end
  end

  task automatic cyc_wait(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic idle_inputs();
    en = 1'b0; div = '0; valid = '0; cycles = '0; periodic = '0; cancel = '0; pclr = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    cyc_wait(2);
    rst = 1'b0;
  endtask

  task automatic set_req(input int k, input int n, input bit per);
    cycles[k*CNT_W +: CNT_W] = CNT_W'(n);
    periodic[k] = per;
    valid[k]    = 1'b1;
  endtask

  // Waits up to limit cycles for a pulse on channel k; returns cycles since accept or -1.
  task automatic wait_pulse(input int k, input int start, input int limit, output int got);
    got = -1;
    for (int c = start; c <= limit; c++) begin
      @(negedge clk);
      if (expire[k]) begin
        got = c;
        break;
      end
    end
  endtask

  typedef struct {
    int div;
    int cyc;
    int lat;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int got, prev, npulse;
    rst = 1'b1;
    idle_inputs();
    // Accept happens with the prescaler at 0; pulse lands N*(D+1) cycles later (N+1 for D=0).
    vecs[0] = '{div: 0, cyc: 5, lat: 6};
    vecs[1] = '{div: 0, cyc: 0, lat: 2};
    vecs[2] = '{div: 0, cyc: 1, lat: 2};
    vecs[3] = '{div: 1, cyc: 3, lat: 6};
    vecs[4] = '{div: 3, cyc: 2, lat: 8};
    vecs[5] = '{div: 2, cyc: 4, lat: 12};
    vecs[6] = '{div: 7, cyc: 1, lat: 8};
    vecs[7] = '{div: 4, cyc: 3, lat: 15};

    cyc_wait(2);
    @(negedge clk);
    check("reset_outs", {busy, expire, pend, irq}, '0);
    cyc_wait(1);
    rst = 1'b0;
    chk_on = 1'b1;

    foreach (vecs[i]) begin
      do_reset();
      en = 1'b1; div = DIV_W'(vecs[i].div);
      set_req(0, vecs[i].cyc, 1'b0);
      cyc_wait(1);
      valid = '0;
      wait_pulse(0, 1, 40, got);
      check($sformatf("vec%0d_latency", i), got, vecs[i].lat);
      check($sformatf("vec%0d_expire_only_ch0", i), expire, 4'b0001);
      check($sformatf("vec%0d_busy_pend_irq", i), {busy[0], pend[0], irq}, 3'b011);
    end

    // Periodic channel 1, div=3, two ticks per period
    do_reset();
    en = 1'b1; div = 16'd3;
    set_req(1, 2, 1'b1);
    cyc_wait(1);
    valid = '0;
    wait_pulse(1, 1, 40, got);
    check("per_first", got, 8);
    for (int p = 0; p < 3; p++) begin
      prev = got;
      wait_pulse(1, got + 1, got + 40, got);
      check("per_interval", got - prev, 8);
    end
    cyc_wait(1);
    cancel[1] = 1'b1;
    cyc_wait(1);
    cancel[1] = 1'b0;
    npulse = 0;
    repeat (20) begin
      @(negedge clk);
      if (expire[1]) npulse++;
    end
    check("per_cancel_pulses", npulse, 0);
    check("per_cancel_busy", busy[1], 1'b0);

    // Cancel in the final-tick cycle
    do_reset();
    en = 1'b1;
    set_req(0, 3, 1'b0);
    cyc_wait(1);
    valid = '0;
    cyc_wait(2);
    cancel[0] = 1'b1;
    cyc_wait(1);
    cancel[0] = 1'b0;
    npulse = 0;
    repeat (5) begin
      @(negedge clk);
      if (expire[0]) npulse++;
    end
    check("cancel_last_pulses", npulse, 0);
    check("cancel_last_pend_busy", {pend[0], busy[0], irq}, 3'b000);

    // Pending clear held across the expiry and pulse cycles
    do_reset();
    en = 1'b1;
    set_req(0, 3, 1'b0);
    cyc_wait(1);
    valid = '0;
    cyc_wait(2);
    pclr[0] = 1'b1;
    cyc_wait(1);
    @(negedge clk);
    check("clr_fire_pulse", {expire[0], pend[0]}, 2'b11);
    cyc_wait(1);
    @(negedge clk);
    check("clr_pulse_pend", pend[0], 1'b1);
    cyc_wait(1);
    pclr[0] = 1'b0;
    @(negedge clk);
    check("clr_done", {pend[0], irq}, 2'b00);

    // cycles=0 behaves as 1
    do_reset();
    en = 1'b1;
    set_req(0, 0, 1'b0);
    cyc_wait(1);
    valid = '0;
    @(negedge clk);
    check("zero_t1", expire[0], 1'b0);
    @(negedge clk);
    check("zero_t2", expire[0], 1'b1);

    // Valid together with cancel on an IDLE channel
    do_reset();
    en = 1'b1;
    set_req(0, 5, 1'b0);
    cancel[0] = 1'b1;
    @(negedge clk);
    check("vc_ready", ready[0], 1'b0);
    cyc_wait(1);
    valid = '0; cancel = '0;
    @(negedge clk);
    check("vc_busy", busy[0], 1'b0);

    // All channels at once
    do_reset();
    en = 1'b1;
    for (int k = 0; k < NUM_CH; k++) set_req(k, 4, 1'b0);
    cyc_wait(1);
    valid = '0;
    wait_pulse(0, 1, 40, got);
    check("all_lat", got, 5);
    check("all_expire", expire, 4'b1111);

    // en_i low for 10 cycles mid-count
    do_reset();
    en = 1'b1;
    set_req(0, 8, 1'b0);
    cyc_wait(1);
    valid = '0;
    cyc_wait(2);
    en = 1'b0;
    @(negedge clk);
    check("en_low_busy_ready", {busy[0], ready[0]}, 2'b10);
    cyc_wait(10);
    en = 1'b1;
    wait_pulse(0, 13, 60, got);
    check("en_low_lat", got, 19);

    // Reset while channel 2 is on its last tick
    do_reset();
    en = 1'b1;
    set_req(2, 3, 1'b0);
    cyc_wait(1);
    valid = '0;
    cyc_wait(2);
    rst = 1'b1;
    #1;
    check("rst_mid_outs", {busy, expire, pend, irq}, '0);
    cyc_wait(1);
    rst = 1'b0;
    npulse = 0;
    repeat (5) begin
      @(negedge clk);
      if (expire != '0) npulse++;
    end
    check("rst_mid_pulses", npulse, 0);
    cyc_wait(1);
    set_req(2, 2, 1'b0);
    cyc_wait(1);
    valid = '0;
    wait_pulse(2, 1, 40, got);
    check("rst_rearm_lat", got, 3);

    // Randomized phase against the model
    do_reset();
    div = 16'd1;
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      en  = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 99) == 0) div = DIV_W'($urandom_range(0, 3));
      for (int k = 0; k < NUM_CH; k++) begin
        valid[k]    = ($urandom_range(0, 3) == 0);
        periodic[k] = $urandom_range(0, 1);
        cycles[k*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 6));
        cancel[k]   = ($urandom_range(0, 19) == 0);
        pclr[k]     = ($urandom_range(0, 7) == 0);
      end
      cyc_wait(1);
    end
    rst = 1'b0;
    idle_inputs();
    cyc_wait(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
